// File: rtl/if_stage_pc.sv
// Instruction-fetch stage: program counter, next-PC mux and IF/ID pipeline register.
// Stall (IF_WPC=0) freezes everything; a flush loads a bubble and does not count as a fetch.
module if_stage_pc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ROM_ADDR_W = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  IF_WPC,
  input  logic [1:0]            Wpc,
  input  logic                  IF_flush,
  input  logic [31:0]           rs_data,
  input  logic [31:0]           ID_sign_extend,
  input  logic [31:0]           rom_instruction,
  output logic [ROM_ADDR_W-1:0] rom_adr,
  output logic [31:0]           PC,
  output logic [31:0]           IF_ID_instruction,
  output logic [31:0]           IF_ID_PC_plus_4,
  output logic [5:0]            IF_ID_op,
  output logic                  IF_ID_valid,
  output logic [31:0]           opcplus4,
  output logic [31:0]           fetch_count
);

  localparam logic [1:0] WPC_SEQ    = 2'b00;
  localparam logic [1:0] WPC_BRANCH = 2'b01;
  localparam logic [1:0] WPC_JUMP   = 2'b10;
  localparam logic [1:0] WPC_REG    = 2'b11;

  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q,  pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus_4;
  logic [31:0] target;

  assign pc_plus_4 = pc_q + 32'd4;

  // Branch/jump targets are relative to the instruction sitting in ID, not the fetch PC.
  always_comb begin
    target = pc_plus_4;
    case (Wpc)
      WPC_SEQ:    target = pc_plus_4;
      WPC_BRANCH: target = pcp4_q + (ID_sign_extend << 2);
      WPC_JUMP:   target = {pcp4_q[31:28], instr_q[25:0], 2'b00};
      WPC_REG:    target = {rs_data[31:2], 2'b00};
      default:    target = pc_plus_4;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (IF_WPC) begin
      pc_d = target;
      if (IF_flush) begin
        instr_d = 32'd0;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
      end else begin
        instr_d = rom_instruction;
        pcp4_d  = pc_plus_4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign rom_adr           = pc_q[ROM_ADDR_W+1:2];
  assign PC                = pc_q;
  assign IF_ID_instruction = instr_q;
  assign IF_ID_PC_plus_4   = pcp4_q;
  assign IF_ID_op          = instr_q[31:26];
  assign IF_ID_valid       = valid_q;
  assign opcplus4          = pcp4_q;
  assign fetch_count       = count_q;

endmodule

// File: tb/tb_if_stage_pc.sv
// Directed bench for if_stage_pc: expected IF/ID state is queued per step and checked after each edge.
module tb_if_stage_pc;

  logic        clock;
  logic        reset;
  logic        IF_WPC;
  logic [1:0]  Wpc;
  logic        IF_flush;
  logic [31:0] rs_data;
  logic [31:0] ID_sign_extend;
  logic [31:0] rom_instruction;
  logic [13:0] rom_adr;
  logic [31:0] PC;
  logic [31:0] IF_ID_instruction;
  logic [31:0] IF_ID_PC_plus_4;
  logic [5:0]  IF_ID_op;
  logic        IF_ID_valid;
  logic [31:0] opcplus4;
  logic [31:0] fetch_count;

  logic        rom_force;
  logic [31:0] rom_force_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pcp4;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  if_stage_pc dut (
    .clock            (clock),
    .reset            (reset),
    .IF_WPC           (IF_WPC),
    .Wpc              (Wpc),
    .IF_flush         (IF_flush),
    .rs_data          (rs_data),
    .ID_sign_extend   (ID_sign_extend),
    .rom_instruction  (rom_instruction),
    .rom_adr          (rom_adr),
    .PC               (PC),
    .IF_ID_instruction(IF_ID_instruction),
    .IF_ID_PC_plus_4  (IF_ID_PC_plus_4),
    .IF_ID_op         (IF_ID_op),
    .IF_ID_valid      (IF_ID_valid),
    .opcplus4         (opcplus4),
    .fetch_count      (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM model: word n holds 0x1000_0000 + n unless a test overrides it.
  always_comb rom_instruction = rom_force ? rom_force_val : (32'h1000_0000 + {18'd0, rom_adr});

  always @(posedge clock) begin
    if (reset) begin
      assert (!(IF_flush && !IF_WPC))
      else begin
        errors++;
        $error("FAIL flush_during_stall: observed IF_flush=%0b IF_WPC=%0b expected no flush while stalled", IF_flush, IF_WPC);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] pcp4, input logic valid, input logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.ins = ins; e.pcp4 = pcp4; e.valid = valid; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=0 entries expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},    PC,                e.pc);
      chk({e.tag, ".ins"},   IF_ID_instruction, e.ins);
      chk({e.tag, ".pcp4"},  IF_ID_PC_plus_4,   e.pcp4);
      chk({e.tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, e.valid});
      chk({e.tag, ".cnt"},   fetch_count,       e.cnt);
    end
  endtask

  // Drive one cycle of inputs, queue the expected result, and check it just after the edge.
  task automatic step(input logic wpc_en, input logic [1:0] sel, input logic flush,
                      input string tag, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] pcp4, input logic valid, input logic [31:0] cnt);
    IF_WPC   = wpc_en;
    Wpc      = sel;
    IF_flush = flush;
    push(tag, pc, ins, pcp4, valid, cnt);
    @(posedge clock);
    #1;
    compare_front();
  endtask

  initial begin
    reset          = 1'b0;
    IF_WPC         = 1'b1;
    Wpc            = 2'b00;
    IF_flush       = 1'b0;
    rs_data        = 32'd0;
    ID_sign_extend = 32'd0;
    rom_force      = 1'b0;
    rom_force_val  = 32'd0;

    #2;
    push("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    compare_front();
    chk("reset.rom_adr", {18'd0, rom_adr}, 32'h0);

    #5 reset = 1'b1;

    step(1, 2'b00, 0, "seq1", 32'h04, 32'h1000_0000, 32'h04, 1, 32'd1);
    step(1, 2'b00, 0, "seq2", 32'h08, 32'h1000_0001, 32'h08, 1, 32'd2);
    step(1, 2'b00, 0, "seq3", 32'h0C, 32'h1000_0002, 32'h0C, 1, 32'd3);
    step(1, 2'b00, 0, "seq4", 32'h10, 32'h1000_0003, 32'h10, 1, 32'd4);
    step(1, 2'b00, 0, "seq5", 32'h14, 32'h1000_0004, 32'h14, 1, 32'd5);

    ID_sign_extend = 32'hFFFF_FFFE;
    step(1, 2'b01, 1, "beq", 32'h0C, 32'h0, 32'h0, 0, 32'd5);

    rs_data = 32'h1000_0004;
    step(1, 2'b11, 0, "jr_noflush", 32'h1000_0004, 32'h1000_0003, 32'h10, 1, 32'd6);

    rom_force = 1'b1; rom_force_val = 32'h0800_0010;
    step(1, 2'b00, 0, "fetch_j", 32'h1000_0008, 32'h0800_0010, 32'h1000_0008, 1, 32'd7);
    rom_force = 1'b0;
    chk("j.op", {26'd0, IF_ID_op}, 32'h02);
    step(1, 2'b10, 1, "jump", 32'h1000_0040, 32'h0, 32'h0, 0, 32'd7);

    step(1, 2'b00, 0, "fetch_jalr", 32'h1000_0044, 32'h1000_0010, 32'h1000_0044, 1, 32'd8);
    chk("jalr.opcplus4", opcplus4, 32'h1000_0044);
    rs_data = 32'h0000_0035;
    step(1, 2'b11, 1, "jalr", 32'h34, 32'h0, 32'h0, 0, 32'd8);

    ID_sign_extend = 32'h0000_0010;
    step(0, 2'b01, 0, "stall1", 32'h34, 32'h0, 32'h0, 0, 32'd8);
    step(0, 2'b01, 0, "stall2", 32'h34, 32'h0, 32'h0, 0, 32'd8);
    step(1, 2'b00, 0, "resume1", 32'h38, 32'h1000_000D, 32'h38, 1, 32'd9);
    step(0, 2'b10, 0, "stall_valid", 32'h38, 32'h1000_000D, 32'h38, 1, 32'd9);
    step(1, 2'b00, 0, "resume2", 32'h3C, 32'h1000_000E, 32'h3C, 1, 32'd10);
    step(1, 2'b00, 0, "resume3", 32'h40, 32'h1000_000F, 32'h40, 1, 32'd11);

    #2 reset = 1'b0;
    #1;
    push("async_reset", 32'h0, 32'h0, 32'h0, 0, 32'd0);
    compare_front();
    #1 reset = 1'b1;
    step(1, 2'b00, 0, "post_reset", 32'h04, 32'h1000_0000, 32'h04, 1, 32'd1);

    rs_data = 32'hFFFF_FFFF;
    step(1, 2'b11, 1, "to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 32'd1);
    chk("top.rom_adr", {18'd0, rom_adr}, 32'h0000_3FFF);
    step(1, 2'b00, 0, "wrap", 32'h0, 32'h1000_3FFF, 32'h0, 1, 32'd2);
    chk("wrap.rom_adr", {18'd0, rom_adr}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
